// File: rtl/life_scheduler.sv
// Generation scheduler for a double-buffered Game of Life engine.
// Sequences pattern load, timed or single-stepped evolution and buffer swap.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 level: 1 evolves continuously, 0 pauses
//   reload              pulse: re-copy the initial pattern
//   step                pulse: one generation while paused
//   period              clk cycles between generations (0 acts as 1)
//   init_finish         done flag from the init copier
//   evolve_done         done flag from the evolution engine
//   init_start          toggle: each transition requests one pattern copy
//   evolve_start        toggle: each transition requests one generation
//   buf_sel             front buffer index; engine writes into !buf_sel
//   busy                high outside PAUSE and WAIT (and during reset)
//   generation          generations completed since the last load
//
// Configuration macro: LIFE_SINGLE_STEP_EN enables single-step from PAUSE.
// Without it the step input is ignored.

module life_scheduler #(
    parameter int PERIOD_W = 24,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                reload,
    input  logic                step,
    input  logic [PERIOD_W-1:0] period,
    input  logic                init_finish,
    input  logic                evolve_done,
    output logic                init_start,
    output logic                evolve_start,
    output logic                buf_sel,
    output logic                busy,
    output logic [GEN_W-1:0]    generation
);

    typedef enum logic [2:0] {
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_PAUSE,
        S_WAIT,
        S_EVO_REQ,
        S_EVO_WAIT,
        S_SWAP
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;
    logic                pending;
    logic                init_q;
    logic                evo_q;
    logic                init_rise;
    logic                evo_rise;
    logic [PERIOD_W-1:0] period_last;

`ifdef LIFE_SINGLE_STEP_EN
    // Marks a generation launched by step so SWAP returns to PAUSE.
    logic                step_gen;
`else
    logic                unused_step;
    assign unused_step = step;
`endif

    // Done flags stay high until the next request clears them, so only
    // their rising edge means "finished".
    assign init_rise = init_finish & ~init_q;
    assign evo_rise  = evolve_done & ~evo_q;

    // Last counter value in WAIT; period 0 behaves like period 1.
    assign period_last = (period == '0) ? '0 : period - 1'b1;

    // Decoded from the state register; LOAD_REQ is the reset state.
    assign busy = (state != S_PAUSE) && (state != S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD_REQ;
            init_start   <= 1'b0;
            evolve_start <= 1'b0;
            buf_sel      <= 1'b0;
            generation   <= '0;
            cnt          <= '0;
            last         <= '0;
            pending      <= 1'b0;
            init_q       <= 1'b0;
            evo_q        <= 1'b0;
`ifdef LIFE_SINGLE_STEP_EN
            step_gen     <= 1'b0;
`endif
        end else begin
            init_q <= init_finish;
            evo_q  <= evolve_done;

            unique case (state)
                S_LOAD_REQ: begin
                    init_start <= ~init_start;
                    generation <= '0;
                    buf_sel    <= 1'b0;
                    pending    <= reload;
`ifdef LIFE_SINGLE_STEP_EN
                    step_gen   <= 1'b0;
`endif
                    state      <= S_LOAD_WAIT;
                end

                S_LOAD_WAIT: begin
                    if (reload) begin
                        pending <= 1'b1;
                    end
                    if (init_rise) begin
                        if (pending || reload) begin
                            state <= S_LOAD_REQ;
                        end else if (run) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                            last  <= period_last;
                        end else begin
                            state <= S_PAUSE;
                        end
                    end
                end

                S_PAUSE: begin
                    if (reload) begin
                        state <= S_LOAD_REQ;
`ifdef LIFE_SINGLE_STEP_EN
                    end else if (step) begin
                        state    <= S_EVO_REQ;
                        step_gen <= 1'b1;
`endif
                    end else if (run) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                        last  <= period_last;
                    end
                end

                S_WAIT: begin
                    if (reload) begin
                        state <= S_LOAD_REQ;
                    end else if (!run) begin
                        state <= S_PAUSE;
                        cnt   <= '0;
                    end else if (cnt == last) begin
                        state <= S_EVO_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_EVO_REQ: begin
                    evolve_start <= ~evolve_start;
                    if (reload) begin
                        pending <= 1'b1;
                    end
                    state <= S_EVO_WAIT;
                end

                S_EVO_WAIT: begin
                    if (reload) begin
                        pending <= 1'b1;
                    end
                    // A pending reload discards the new generation.
                    if (evo_rise) begin
                        if (pending || reload) begin
                            state <= S_LOAD_REQ;
                        end else begin
                            state <= S_SWAP;
                        end
                    end
                end

                S_SWAP: begin
                    buf_sel    <= ~buf_sel;
                    generation <= generation + 1'b1;
                    if (pending || reload) begin
                        state <= S_LOAD_REQ;
`ifdef LIFE_SINGLE_STEP_EN
                    end else if (step_gen) begin
                        state    <= S_PAUSE;
                        step_gen <= 1'b0;
`endif
                    end else if (run) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                        last  <= period_last;
                    end else begin
                        state <= S_PAUSE;
                    end
                end

                default: begin
                    state <= S_LOAD_REQ;
                end
            endcase
        end
    end

endmodule
